// File: rtl/gauss_sched.sv
// gauss_sched: command-level scheduler for the Gaussian-elimination `phase`
// engine. A host command names a first column block and a mode; the scheduler
// launches `phase` once per block from that block up to NB-1 (or once only in
// single mode), waiting for each phase_done before the next launch. A per-phase
// watchdog, abort with safe drain, sticky timeout error and a cycle counter
// are included.
//
// Handshake: a command is accepted on any rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and the host must
// hold cmd_valid/cmd_block/cmd_single stable until that edge.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake
//   cmd_block, cmd_single first block to process, run-one-phase mode
//   abort, err_clr        abort running command, clear sticky error
//   phase_start           one-cycle launch pulse to `phase`
//   phase_start_block     block index for the launch, held until next launch
//   phase_done            `phase` completion pulse
//   busy                  scheduler not idle
//   done/aborted/err_range one-cycle status pulses (mutually exclusive)
//   err_timeout           sticky watchdog error
//   cur_block             block currently being processed
//   cycles                busy cycles from accept to done/abort/error
//   state_dbg             current FSM state encoding
module gauss_sched #(
  parameter int N       = 4,
  parameter int L       = 8,
  parameter int K       = 16,
  parameter int TIMEOUT = 4096,
  localparam int BW     = $clog2(K/N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [BW-1:0] cmd_block,
  input  logic          cmd_single,
  input  logic          abort,
  input  logic          err_clr,
  output logic          phase_start,
  output logic [BW-1:0] phase_start_block,
  input  logic          phase_done,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          err_range,
  output logic          err_timeout,
  output logic [BW-1:0] cur_block,
  output logic [31:0]   cycles,
  output logic [2:0]    state_dbg
);

  localparam int WW = $clog2(TIMEOUT+1);
  localparam logic [BW-1:0] NB_L    = BW'(K/N);
  localparam logic [BW-1:0] LAST_L  = BW'(K/N-1);
  localparam logic [WW-1:0] TO_M1   = WW'(TIMEOUT-1);
  localparam logic [WW-1:0] TO_FULL = WW'(TIMEOUT);

  // L only configures the attached `phase`; here it is just sanity-checked.
  if ((K % N) != 0 || L < 1) begin : g_bad_cfg
    $error("gauss_sched: K must be a multiple of N and L must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t        state;
  logic          single_q;
  logic [WW-1:0] wdog;

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign phase_start = (state == S_LAUNCH);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_IDLE;
      single_q          <= 1'b0;
      wdog              <= '0;
      cur_block         <= '0;
      phase_start_block <= '0;
      done              <= 1'b0;
      aborted           <= 1'b0;
      err_range         <= 1'b0;
      err_timeout       <= 1'b0;
      cycles            <= '0;
    end else begin
      done      <= 1'b0;
      aborted   <= 1'b0;
      err_range <= 1'b0;

      // Count busy cycles up to the terminating edge; the count freezes once
      // the command ends, including when it ends in ERR.
      if (state != S_IDLE && state != S_ERR && cycles != 32'hFFFF_FFFF)
        cycles <= cycles + 32'd1;

      // Watchdog saturates at TIMEOUT so an abort that lands on the expiry
      // cycle still trips the >= test in DRAIN instead of wrapping.
      if ((state == S_WAIT || state == S_DRAIN) && wdog != TO_FULL)
        wdog <= wdog + WW'(1);

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_block >= NB_L) begin
              err_range <= 1'b1;
            end else begin
              cur_block         <= cmd_block;
              phase_start_block <= cmd_block;
              single_q          <= cmd_single;
              cycles            <= '0;
              state             <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          // The launch pulse is issued this cycle regardless of abort; an
          // abort just means we must wait out the running phase.
          wdog  <= '0;
          state <= abort ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (abort) begin
            if (phase_done) begin
              aborted <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_DRAIN;
            end
          end else if (phase_done) begin
            if (single_q || cur_block == LAST_L) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              cur_block         <= cur_block + BW'(1);
              phase_start_block <= cur_block + BW'(1);
              state             <= S_LAUNCH;
            end
          end else if (wdog >= TO_M1) begin
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end
        end
        S_DRAIN: begin
          if (phase_done) begin
            aborted <= 1'b1;
            state   <= S_IDLE;
          end else if (wdog >= TO_M1) begin
            err_timeout <= 1'b1;
            state       <= S_ERR;
          end
        end
        S_ERR: begin
          if (err_clr) begin
            err_timeout <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_sched.sv
// Directed testbench for gauss_sched (K=16, N=4, TIMEOUT=64).
module tb_gauss_sched;

  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [BW-1:0] cmd_block = '0;
  logic          cmd_single = 1'b0;
  logic          abort = 1'b0;
  logic          err_clr = 1'b0;
  logic          phase_start;
  logic [BW-1:0] phase_start_block;
  logic          phase_done = 1'b0;
  logic          busy, done, aborted, err_range, err_timeout;
  logic [BW-1:0] cur_block;
  logic [31:0]   cycles;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected phase_start_block for each launch, in order.
  logic [BW-1:0] exp_q[$];

  gauss_sched #(.N(4), .L(8), .K(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_block(cmd_block), .cmd_single(cmd_single),
    .abort(abort), .err_clr(err_clr),
    .phase_start(phase_start), .phase_start_block(phase_start_block),
    .phase_done(phase_done),
    .busy(busy), .done(done), .aborted(aborted),
    .err_range(err_range), .err_timeout(err_timeout),
    .cur_block(cur_block), .cycles(cycles), .state_dbg(state_dbg)
  );

  // ---------------- clock / global time limit ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: run did not finish, got still-running want finished");
    $fatal(1, "time limit");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Launch scoreboard: every phase_start must match the next queued block.
  always begin
    @(posedge clk);
    #1;
    if (rst && phase_start) begin
      if (exp_q.size() == 0) check_eq("extra_launch", phase_start, 0);
      else check_eq("launch_block", phase_start_block, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge.
  task automatic send_cmd(input logic [BW-1:0] blk, input logic single);
    cmd_valid  = 1'b1;
    cmd_block  = blk;
    cmd_single = single;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Wait dly cycles, pulse phase_done for one cycle; returns in the cycle
  // after the pulse.
  task automatic serve(input int dly);
    repeat (dly) tick();
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    repeat (3) tick();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_phase_start", phase_start, 0);
    check_eq("rst_cycles", cycles, 0);
    check_eq("rst_cur_block", cur_block, 0);
    check_eq("rst_err_timeout", err_timeout, 0);
    rst = 1'b1;
    tick();

    // Full run from block 0: four launches, done after the last phase_done.
    exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    send_cmd(3'd0, 1'b0);
    check_eq("full_first_launch", phase_start, 1);
    for (int i = 0; i < 4; i++) begin
      serve(3 + i);
      if (i < 3) begin
        check_eq("full_relaunch", phase_start, 1);
        check_eq("full_cur_block", cur_block, i + 1);
        check_eq("full_no_done", done, 0);
      end else begin
        check_eq("full_done", done, 1);
        check_eq("full_idle", busy, 0);
        check_eq("full_no_launch", phase_start, 0);
      end
    end
    tick();
    check_eq("full_done_pulse", done, 0);
    check_eq("full_q_empty", exp_q.size(), 0);

    // Single mode at block 2: accept-to-done is 1 launch + 5 wait cycles.
    exp_q.push_back(3'd2);
    send_cmd(3'd2, 1'b1);
    serve(5);
    check_eq("single_done", done, 1);
    check_eq("single_cur_block", cur_block, 2);
    check_eq("single_cycles", cycles, 6);
    tick();
    check_eq("single_done_pulse", done, 0);
    check_eq("single_cycles_frozen", cycles, 6);
    check_eq("single_q_empty", exp_q.size(), 0);

    // Out-of-range block.
    send_cmd(3'd4, 1'b0);
    check_eq("range_pulse", err_range, 1);
    check_eq("range_no_launch", phase_start, 0);
    check_eq("range_ready", cmd_ready, 1);
    tick();
    check_eq("range_pulse_end", err_range, 0);

    // Abort during WAIT of block 1, drain until phase_done.
    exp_q = '{3'd0, 3'd1};
    send_cmd(3'd0, 1'b0);
    serve(2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_drain_busy", busy, 1);
    serve(9);
    check_eq("abort_pulse", aborted, 1);
    check_eq("abort_idle", busy, 0);
    check_eq("abort_no_done", done, 0);
    check_eq("abort_cur_block", cur_block, 1);
    tick();
    check_eq("abort_pulse_end", aborted, 0);
    check_eq("abort_q_empty", exp_q.size(), 0);

    // Abort and phase_done together: straight to IDLE with aborted.
    exp_q.push_back(3'd3);
    send_cmd(3'd3, 1'b0);
    tick();
    abort = 1'b1;
    phase_done = 1'b1;
    tick();
    abort = 1'b0;
    phase_done = 1'b0;
    check_eq("abdone_aborted", aborted, 1);
    check_eq("abdone_no_done", done, 0);
    check_eq("abdone_idle", busy, 0);

    // Watchdog: WAIT entered at accept+1; error 64 cycles later.
    exp_q.push_back(3'd1);
    send_cmd(3'd1, 1'b1);
    repeat (64) tick();
    check_eq("wd_not_yet", err_timeout, 0);
    tick();
    check_eq("wd_err", err_timeout, 1);
    check_eq("wd_busy", busy, 1);
    check_eq("wd_not_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_block = 3'd0;
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check_eq("wd_ignored_cmd", phase_start, 0);
    check_eq("wd_sticky", err_timeout, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_ready", cmd_ready, 1);
    check_eq("clr_err", err_timeout, 0);
    check_eq("clr_idle", busy, 0);

    // Reset mid-WAIT, then a clean new command.
    exp_q.push_back(3'd2);
    send_cmd(3'd2, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_ready", cmd_ready, 1);
    check_eq("mrst_cur_block", cur_block, 0);
    check_eq("mrst_psb", phase_start_block, 0);
    check_eq("mrst_cycles", cycles, 0);
    check_eq("mrst_done", done, 0);
    rst = 1'b1;
    tick();
    exp_q.push_back(3'd0);
    send_cmd(3'd0, 1'b1);
    check_eq("post_rst_launch", phase_start, 1);
    serve(2);
    check_eq("post_rst_done", done, 1);
    check_eq("post_rst_q_empty", exp_q.size(), 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
